// File: rtl/axi_stream_remove_header_pkg.sv
// Shared definitions for the AXI-Stream header insert/remove pair:
// state encoding, default widths and keep/count helpers.
package axi_stream_remove_header_pkg;

  localparam int DEF_DATA_WD      = 32;
  localparam int DEF_DATA_BYTE_WD = DEF_DATA_WD / 8;
  localparam int DEF_BYTE_CNT_WD  = $clog2(DEF_DATA_BYTE_WD) + 1;
  localparam int MAX_BYTES        = 64;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FIRST  = 2'd1,
    STREAM = 2'd2,
    FLUSH  = 2'd3
  } rh_state_e;

  // MSB-aligned keep with cnt leading ones out of nbytes (cnt clamps to nbytes).
  function automatic logic [MAX_BYTES-1:0] keep_from_cnt(input int cnt, input int nbytes);
    logic [MAX_BYTES-1:0] k;
    int c;
    k = '0;
    c = (cnt > nbytes) ? nbytes : cnt;
    for (int i = 0; i < MAX_BYTES; i++) begin
      if ((i < nbytes) && (i >= nbytes - c)) k[i] = 1'b1;
    end
    return k;
  endfunction

  function automatic int count_ones_msb(input logic [MAX_BYTES-1:0] keep);
    int n;
    n = 0;
    for (int i = 0; i < MAX_BYTES; i++) begin
      n = n + int'(keep[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/axi_stream_remove_header_realign.sv
// Combinational byte merge: residual bytes followed by the new beat, plus the
// header split and post-header remainder used on the first beat of a packet.
module axis_byte_realign
  import axi_stream_remove_header_pkg::*;
#(
  parameter int DATA_WD      = DEF_DATA_WD,
  parameter int DATA_BYTE_WD = DATA_WD / 8,
  parameter int BYTE_CNT_WD  = $clog2(DATA_BYTE_WD) + 1
) (
  input  logic [DATA_WD-1:0]      resid,
  input  logic [BYTE_CNT_WD-1:0]  resid_cnt,
  input  logic [DATA_WD-1:0]      data,
  input  logic [DATA_BYTE_WD-1:0] keep,
  input  logic [BYTE_CNT_WD-1:0]  shift,
  output logic [DATA_WD-1:0]      merged_data,
  output logic [DATA_BYTE_WD-1:0] merged_keep,
  output logic [DATA_WD-1:0]      carry_data,
  output logic [BYTE_CNT_WD-1:0]  carry_cnt,
  output logic [DATA_WD-1:0]      head_data,
  output logic [DATA_BYTE_WD-1:0] head_keep,
  output logic [DATA_WD-1:0]      strip_data,
  output logic [DATA_BYTE_WD-1:0] strip_keep,
  output logic [BYTE_CNT_WD-1:0]  strip_cnt
);

  localparam int SUM_WD = BYTE_CNT_WD + 1;
  localparam logic [SUM_WD-1:0] FULL_SUM = SUM_WD'(DATA_BYTE_WD);

  logic [DATA_WD-1:0]     data_m;
  logic [2*DATA_WD-1:0]   wide;
  logic [BYTE_CNT_WD-1:0] beat_cnt;
  logic [BYTE_CNT_WD-1:0] head_cnt;
  logic [BYTE_CNT_WD-1:0] merged_cnt;
  logic [SUM_WD-1:0]      total;
  logic [MAX_BYTES-1:0]   merged_keep_w;
  logic [MAX_BYTES-1:0]   head_keep_w;
  logic [MAX_BYTES-1:0]   strip_keep_w;
  logic                   unused_keep_bits;

  // Bytes outside keep are forced to zero so padding never leaks downstream.
  always_comb begin
    data_m    = '0;
    head_data = '0;
    for (int i = 0; i < DATA_BYTE_WD; i++) begin
      data_m[8*i +: 8]    = keep[i] ? data[8*i +: 8] : 8'h00;
      head_data[8*i +: 8] = head_keep[i] ? data_m[8*i +: 8] : 8'h00;
    end
  end

  assign beat_cnt = BYTE_CNT_WD'(count_ones_msb(MAX_BYTES'(keep)));

  assign wide  = {resid, {DATA_WD{1'b0}}} | ({data_m, {DATA_WD{1'b0}}} >> (8 * int'(resid_cnt)));
  assign total = SUM_WD'(resid_cnt) + SUM_WD'(beat_cnt);

  assign merged_cnt  = (total > FULL_SUM) ? BYTE_CNT_WD'(DATA_BYTE_WD) : total[BYTE_CNT_WD-1:0];
  assign carry_cnt   = (total > FULL_SUM) ? BYTE_CNT_WD'(total - FULL_SUM) : '0;
  assign merged_data = wide[2*DATA_WD-1 -: DATA_WD];
  assign carry_data  = wide[DATA_WD-1:0];

  assign head_cnt   = (shift < beat_cnt) ? shift : beat_cnt;
  assign strip_data = data_m << (8 * int'(shift));
  assign strip_cnt  = (beat_cnt > shift) ? (beat_cnt - shift) : '0;

  assign merged_keep_w = keep_from_cnt(int'(merged_cnt), DATA_BYTE_WD);
  assign head_keep_w   = keep_from_cnt(int'(head_cnt), DATA_BYTE_WD);
  assign strip_keep_w  = keep_from_cnt(int'(strip_cnt), DATA_BYTE_WD);

  assign merged_keep = merged_keep_w[DATA_BYTE_WD-1:0];
  assign head_keep   = head_keep_w[DATA_BYTE_WD-1:0];
  assign strip_keep  = strip_keep_w[DATA_BYTE_WD-1:0];

  assign unused_keep_bits = ^{merged_keep_w[MAX_BYTES-1:DATA_BYTE_WD],
                              head_keep_w[MAX_BYTES-1:DATA_BYTE_WD],
                              strip_keep_w[MAX_BYTES-1:DATA_BYTE_WD]};

endmodule

// File: rtl/axi_stream_remove_header.sv
// Strips a 0..DATA_BYTE_WD byte header from each AXI-Stream packet and re-packs
// the payload MSB-aligned; stripped bytes appear on a one-cycle side-band.
//   state  | meaning
//   IDLE   | waiting for the header-length command
//   FIRST  | waiting for the first beat (header split off)
//   STREAM | merging residual bytes with each new beat
//   FLUSH  | emitting leftover bytes after the last input beat
module axi_stream_remove_header
  import axi_stream_remove_header_pkg::*;
#(
  parameter int DATA_WD      = DEF_DATA_WD,
  parameter int DATA_BYTE_WD = DATA_WD / 8,
  parameter int BYTE_CNT_WD  = $clog2(DATA_BYTE_WD) + 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    valid_in,
  input  logic [DATA_WD-1:0]      data_in,
  input  logic [DATA_BYTE_WD-1:0] keep_in,
  input  logic                    last_in,
  output logic                    ready_in,
  output logic                    valid_out,
  output logic [DATA_WD-1:0]      data_out,
  output logic [DATA_BYTE_WD-1:0] keep_out,
  output logic                    last_out,
  input  logic                    ready_out,
  input  logic                    valid_remove,
  input  logic [BYTE_CNT_WD-1:0]  byte_remove_cnt,
  output logic                    ready_remove,
  output logic                    valid_header,
  output logic [DATA_WD-1:0]      data_header,
  output logic [DATA_BYTE_WD-1:0] keep_header
);

  localparam logic [BYTE_CNT_WD-1:0] FULL_CNT = BYTE_CNT_WD'(DATA_BYTE_WD);

  rh_state_e              state;
  logic [BYTE_CNT_WD-1:0] s_cnt;
  logic [DATA_WD-1:0]     resid;
  logic [BYTE_CNT_WD-1:0] resid_cnt;
  logic                   slot_free;
  logic                   accept;

  logic [DATA_WD-1:0]      merged_data;
  logic [DATA_BYTE_WD-1:0] merged_keep;
  logic [DATA_WD-1:0]      carry_data;
  logic [BYTE_CNT_WD-1:0]  carry_cnt;
  logic [DATA_WD-1:0]      head_data;
  logic [DATA_BYTE_WD-1:0] head_keep;
  logic [DATA_WD-1:0]      strip_data;
  logic [DATA_BYTE_WD-1:0] strip_keep;
  logic [BYTE_CNT_WD-1:0]  strip_cnt;
  logic [MAX_BYTES-1:0]    resid_keep_w;
  logic [DATA_BYTE_WD-1:0] resid_keep;
  logic                    unused_resid_keep;

  axis_byte_realign #(
    .DATA_WD      (DATA_WD),
    .DATA_BYTE_WD (DATA_BYTE_WD),
    .BYTE_CNT_WD  (BYTE_CNT_WD)
  ) u_realign (
    .resid       (resid),
    .resid_cnt   (resid_cnt),
    .data        (data_in),
    .keep        (keep_in),
    .shift       (s_cnt),
    .merged_data (merged_data),
    .merged_keep (merged_keep),
    .carry_data  (carry_data),
    .carry_cnt   (carry_cnt),
    .head_data   (head_data),
    .head_keep   (head_keep),
    .strip_data  (strip_data),
    .strip_keep  (strip_keep),
    .strip_cnt   (strip_cnt)
  );

  assign resid_keep_w      = keep_from_cnt(int'(resid_cnt), DATA_BYTE_WD);
  assign resid_keep        = resid_keep_w[DATA_BYTE_WD-1:0];
  assign unused_resid_keep = ^resid_keep_w[MAX_BYTES-1:DATA_BYTE_WD];

  assign slot_free    = !valid_out || ready_out;
  assign ready_in     = ((state == FIRST) || (state == STREAM)) && slot_free;
  // Gated by rst_n so no command is taken while reset is held.
  assign ready_remove = (state == IDLE) && rst_n;
  assign accept       = valid_in && ready_in;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      s_cnt        <= '0;
      resid        <= '0;
      resid_cnt    <= '0;
      valid_out    <= 1'b0;
      data_out     <= '0;
      keep_out     <= '0;
      last_out     <= 1'b0;
      valid_header <= 1'b0;
      data_header  <= '0;
      keep_header  <= '0;
    end else begin
      valid_header <= 1'b0;
      if (ready_out) valid_out <= 1'b0;
      case (state)
        IDLE: begin
          if (valid_remove) begin
            s_cnt <= (byte_remove_cnt > FULL_CNT) ? FULL_CNT : byte_remove_cnt;
            state <= FIRST;
          end
        end
        FIRST: begin
          if (accept) begin
            if (s_cnt != '0) begin
              valid_header <= 1'b1;
              data_header  <= head_data;
              keep_header  <= head_keep;
            end
            resid     <= strip_data;
            resid_cnt <= strip_cnt;
            if (last_in) begin
              state <= IDLE;
              if (strip_cnt != '0) begin
                valid_out <= 1'b1;
                data_out  <= strip_data;
                keep_out  <= strip_keep;
                last_out  <= 1'b1;
              end
            end else begin
              state <= STREAM;
            end
          end
        end
        STREAM: begin
          if (accept) begin
            valid_out <= 1'b1;
            data_out  <= merged_data;
            keep_out  <= merged_keep;
            last_out  <= last_in && (carry_cnt == '0);
            resid     <= carry_data;
            resid_cnt <= carry_cnt;
            if (last_in) state <= (carry_cnt == '0) ? IDLE : FLUSH;
          end
        end
        FLUSH: begin
          if (slot_free) begin
            valid_out <= 1'b1;
            data_out  <= resid;
            keep_out  <= resid_keep;
            last_out  <= 1'b1;
            resid     <= '0;
            resid_cnt <= '0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_stream_remove_header.sv
// Directed bench for axi_stream_remove_header: fixed packets with hand-computed
// output beats and header pulses, plus back-pressure and mid-packet reset.
module tb_axi_stream_remove_header;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid_in;
  logic [31:0] data_in;
  logic [3:0]  keep_in;
  logic        last_in;
  logic        ready_in;
  logic        valid_out;
  logic [31:0] data_out;
  logic [3:0]  keep_out;
  logic        last_out;
  logic        ready_out;
  logic        valid_remove;
  logic [2:0]  byte_remove_cnt;
  logic        ready_remove;
  logic        valid_header;
  logic [31:0] data_header;
  logic [3:0]  keep_header;

  int n_checks = 0;
  int n_fail   = 0;

  logic [63:0] out_q[$];
  logic [63:0] hdr_q[$];
  logic [63:0] exp_out[$];
  logic [63:0] exp_hdr[$];

  always #5 clk = ~clk;

  axi_stream_remove_header dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .valid_in        (valid_in),
    .data_in         (data_in),
    .keep_in         (keep_in),
    .last_in         (last_in),
    .ready_in        (ready_in),
    .valid_out       (valid_out),
    .data_out        (data_out),
    .keep_out        (keep_out),
    .last_out        (last_out),
    .ready_out       (ready_out),
    .valid_remove    (valid_remove),
    .byte_remove_cnt (byte_remove_cnt),
    .ready_remove    (ready_remove),
    .valid_header    (valid_header),
    .data_header     (data_header),
    .keep_header     (keep_header)
  );

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] ob(input logic [31:0] d, input logic [3:0] k, input logic l);
    return {27'd0, d, k, l};
  endfunction

  function automatic logic [63:0] hb(input logic [31:0] d, input logic [3:0] k);
    return {28'd0, d, k};
  endfunction

  // Transfers are observed at the falling edge, before the rising edge that completes them.
  always @(negedge clk) begin
    if (valid_out && ready_out) out_q.push_back(ob(data_out, keep_out, last_out));
    if (valid_header) hdr_q.push_back(hb(data_header, keep_header));
  end

  task automatic send_cmd(input logic [2:0] s);
    valid_remove    = 1'b1;
    byte_remove_cnt = s;
    for (int t = 0; t < 40; t++) begin
      @(negedge clk);
      if (ready_remove) break;
    end
    if (!ready_remove) check_eq("cmd_timeout", 64'(ready_remove), 64'd1);
    @(posedge clk);
    #1;
    valid_remove = 1'b0;
  endtask

  task automatic send_beat(input logic [31:0] d, input logic [3:0] k, input logic l);
    valid_in = 1'b1;
    data_in  = d;
    keep_in  = k;
    last_in  = l;
    for (int t = 0; t < 40; t++) begin
      @(negedge clk);
      if (ready_in) break;
    end
    if (!ready_in) check_eq("beat_timeout", 64'(ready_in), 64'd1);
    @(posedge clk);
    #1;
    valid_in = 1'b0;
    last_in  = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic compare_all(input string tag);
    check_eq($sformatf("%s_nout", tag), 64'(out_q.size()), 64'(exp_out.size()));
    for (int i = 0; i < exp_out.size(); i++)
      if (i < out_q.size()) check_eq($sformatf("%s_out%0d", tag, i), out_q[i], exp_out[i]);
    check_eq($sformatf("%s_nhdr", tag), 64'(hdr_q.size()), 64'(exp_hdr.size()));
    for (int i = 0; i < exp_hdr.size(); i++)
      if (i < hdr_q.size()) check_eq($sformatf("%s_hdr%0d", tag, i), hdr_q[i], exp_hdr[i]);
    out_q.delete();
    hdr_q.delete();
    exp_out.delete();
    exp_hdr.delete();
  endtask

  task automatic check_reset(input string tag);
    check_eq({tag, "_valid_out"}, 64'(valid_out), 64'd0);
    check_eq({tag, "_data_out"}, 64'(data_out), 64'd0);
    check_eq({tag, "_keep_out"}, 64'(keep_out), 64'd0);
    check_eq({tag, "_last_out"}, 64'(last_out), 64'd0);
    check_eq({tag, "_valid_header"}, 64'(valid_header), 64'd0);
    check_eq({tag, "_data_header"}, 64'(data_header), 64'd0);
    check_eq({tag, "_keep_header"}, 64'(keep_header), 64'd0);
    check_eq({tag, "_ready_in"}, 64'(ready_in), 64'd0);
    check_eq({tag, "_ready_remove"}, 64'(ready_remove), 64'd0);
  endtask

  task automatic run_s2(input string tag);
    exp_hdr.push_back(hb(32'hAABB0000, 4'b1100));
    exp_out.push_back(ob(32'hCCDDEEFF, 4'b1111, 1'b1));
    send_cmd(3'd2);
    send_beat(32'hAABBCCDD, 4'b1111, 1'b0);
    send_beat(32'hEEFF0011, 4'b1100, 1'b1);
    idle(6);
    compare_all(tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n           = 1'b0;
    valid_in        = 1'b0;
    data_in         = '0;
    keep_in         = '0;
    last_in         = 1'b0;
    ready_out       = 1'b1;
    valid_remove    = 1'b0;
    byte_remove_cnt = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset("rst");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(2);

    // S=1, leftover bytes drained through FLUSH
    exp_hdr.push_back(hb(32'h11000000, 4'b1000));
    exp_out.push_back(ob(32'h22334455, 4'b1111, 1'b0));
    exp_out.push_back(ob(32'h66778800, 4'b1110, 1'b1));
    send_cmd(3'd1);
    send_beat(32'h11223344, 4'b1111, 1'b0);
    send_beat(32'h55667788, 4'b1111, 1'b1);
    idle(6);
    compare_all("s1");

    // input beats are refused while waiting for a command
    valid_in = 1'b1;
    data_in  = 32'h12121212;
    keep_in  = 4'b1111;
    @(negedge clk);
    check_eq("idle_ready_in", 64'(ready_in), 64'd0);
    check_eq("idle_ready_remove", 64'(ready_remove), 64'd1);
    idle(1);
    valid_in = 1'b0;
    idle(2);
    compare_all("idle");

    run_s2("s2");

    // S=4: full-beat header, payload passes unchanged
    exp_hdr.push_back(hb(32'hABCD1234, 4'b1111));
    exp_out.push_back(ob(32'h12345678, 4'b1111, 1'b0));
    exp_out.push_back(ob(32'hDEADBEEF, 4'b1111, 1'b1));
    send_cmd(3'd4);
    send_beat(32'hABCD1234, 4'b1111, 1'b0);
    send_beat(32'h12345678, 4'b1111, 1'b0);
    send_beat(32'hDEADBEEF, 4'b1111, 1'b1);
    idle(6);
    compare_all("s3");

    // S=3 on a 2-byte single-beat packet: header only, empty payload
    exp_hdr.push_back(hb(32'hCAFE0000, 4'b1100));
    send_cmd(3'd3);
    send_beat(32'hCAFEBABE, 4'b1100, 1'b1);
    idle(6);
    compare_all("s4");

    // S=0: one-beat delay, no header pulse, padding byte zeroed
    exp_out.push_back(ob(32'h01020304, 4'b1111, 1'b0));
    exp_out.push_back(ob(32'h05060700, 4'b1110, 1'b1));
    send_cmd(3'd0);
    send_beat(32'h01020304, 4'b1111, 1'b0);
    send_beat(32'h05060708, 4'b1110, 1'b1);
    idle(6);
    compare_all("s4b");

    // header length above the beat width clamps to a full beat
    exp_hdr.push_back(hb(32'h0BADF00D, 4'b1111));
    send_cmd(3'd7);
    send_beat(32'h0BADF00D, 4'b1111, 1'b1);
    idle(6);
    compare_all("clamp");

    // S=1 with downstream stalled while the first output beat is held
    exp_hdr.push_back(hb(32'h11000000, 4'b1000));
    exp_out.push_back(ob(32'h22334455, 4'b1111, 1'b0));
    exp_out.push_back(ob(32'h66778899, 4'b1111, 1'b0));
    exp_out.push_back(ob(32'hAABBCC00, 4'b1110, 1'b1));
    send_cmd(3'd1);
    send_beat(32'h11223344, 4'b1111, 1'b0);
    send_beat(32'h55667788, 4'b1111, 1'b0);
    ready_out = 1'b0;
    valid_in  = 1'b1;
    data_in   = 32'h99AABBCC;
    keep_in   = 4'b1111;
    last_in   = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check_eq($sformatf("s5_hold%0d", c), ob(data_out, keep_out, last_out), ob(32'h22334455, 4'b1111, 1'b0));
      check_eq($sformatf("s5_valid%0d", c), 64'(valid_out), 64'd1);
      check_eq($sformatf("s5_ready_in%0d", c), 64'(ready_in), 64'd0);
    end
    @(posedge clk);
    #1;
    ready_out = 1'b1;
    send_beat(32'h99AABBCC, 4'b1111, 1'b1);
    idle(6);
    compare_all("s5");

    // reset in STREAM drops the packet; no last_out is ever produced
    exp_hdr.push_back(hb(32'hABCD1234, 4'b1111));
    exp_out.push_back(ob(32'h12345678, 4'b1111, 1'b0));
    send_cmd(3'd4);
    send_beat(32'hABCD1234, 4'b1111, 1'b0);
    send_beat(32'h12345678, 4'b1111, 1'b0);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_reset("s6");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(4);
    compare_all("s6");
    run_s2("s6b");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
